banco_registros: RTL and testbench

- Parametrised, clocked successor to the team's combinational 32x32 data memories.
- Provides one write port and two registered read ports, with write-first bypass and an optional hardwired-zero register 0.
- A self-clearing init sequencer zeroes the whole array after reset, or on request, before the block accepts traffic.
- Sits in the datapath as the CPU register bank, between decode (addresses) and ALU operand latches.

---
 rtl/banco_pkg.sv | 15 +
 rtl/banco_registros_init.sv | 57 +++++
 rtl/banco_registros.sv | 101 ++++++++++
 tb/tb_banco_registros.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/banco_pkg.sv
// Shared definitions for the register bank: sequencer state encoding and depth helper.
package banco_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    LISTO = 1'b1
  } estado_t;

  localparam int DEPTH_DEF = 32;

  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/banco_registros_init.sv
// Clear sequencer: walks every address writing zero after reset or a clr request,
// then holds in LISTO until the next clr.
module banco_registros_init
  import banco_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  output logic              listo,
  output logic              init_we,
  output logic [ADDR_W-1:0] init_addr
);

  estado_t           state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      INIT: begin
        // The counter naturally wraps to 0 on the last entry, ready for the next clear.
        cnt_d = cnt_q + ADDR_W'(1);
        if (cnt_q == {ADDR_W{1'b1}}) begin
          state_d = LISTO;
        end
      end
      LISTO: begin
        if (clr) begin
          state_d = INIT;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = INIT;
        cnt_d   = '0;
      end
    endcase
  end

  assign listo     = (state_q == LISTO);
  assign init_we   = (state_q == INIT);
  assign init_addr = cnt_q;

endmodule

// File: rtl/banco_registros.sv
// CPU register bank: one write port, two registered read ports with write-first
// bypass, optional hardwired-zero entry 0, and a self-clearing init sequence.
module banco_registros
  import banco_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] dirEsc,
  input  logic [DATA_W-1:0] datos,
  input  logic [ADDR_W-1:0] dirLec1,
  input  logic [ADDR_W-1:0] dirLec2,
  input  logic              clr,
  output logic [DATA_W-1:0] datosOut1,
  output logic [DATA_W-1:0] datosOut2,
  output logic              listo
);

  localparam int DEPTH = depth_of(ADDR_W);

  logic [DATA_W-1:0] men [DEPTH];

  logic              init_we;
  logic [ADDR_W-1:0] init_addr;
  logic              wr_user;
  logic              wr_keep;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;

  logic [1:0][ADDR_W-1:0] dir_lec;
  logic [1:0][DATA_W-1:0] dout;

  banco_registros_init #(
    .ADDR_W(ADDR_W)
  ) u_init (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .listo    (listo),
    .init_we  (init_we),
    .init_addr(init_addr)
  );

  // clr wins over a coincident write, so it also suppresses the bypass.
  assign wr_user = listo && we && !clr;
  assign wr_keep = wr_user && !((ZERO_REG != 0) && (dirEsc == '0));
  assign mem_we  = init_we || wr_keep;

  always_comb begin
    mem_addr = dirEsc;
    mem_data = datos;
    if (init_we) begin
      mem_addr = init_addr;
      mem_data = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      men[mem_addr] <= mem_data;
    end
  end

  assign dir_lec = {dirLec2, dirLec1};

  for (genvar gi = 0; gi < 2; gi++) begin : gen_rd
    logic [DATA_W-1:0] out_q, out_d;

    always_comb begin
      out_d = '0;
      if (listo) begin
        if ((ZERO_REG != 0) && (dir_lec[gi] == '0)) begin
          out_d = '0;
        end else if (wr_user && (dirEsc == dir_lec[gi])) begin
          out_d = datos;
        end else begin
          out_d = men[dir_lec[gi]];
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        out_q <= '0;
      end else begin
        out_q <= out_d;
      end
    end

    assign dout[gi] = out_q;
  end

  assign datosOut1 = dout[0];
  assign datosOut2 = dout[1];

endmodule

// File: tb/tb_banco_registros.sv
// Self-checking bench for banco_registros: directed test-plan scenarios plus
// randomized traffic checked against an array-based reference model.
module tb_banco_registros;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 32;
  localparam int ZR    = 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          we;
  logic [AW-1:0] dirEsc;
  logic [DW-1:0] datos;
  logic [AW-1:0] dirLec1;
  logic [AW-1:0] dirLec2;
  logic          clr;
  logic [DW-1:0] datosOut1;
  logic [DW-1:0] datosOut2;
  logic          listo;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_ready;
  int            m_left;
  logic [DW-1:0] m_o1, m_o2;

  banco_registros #(
    .DATA_W  (DW),
    .ADDR_W  (AW),
    .ZERO_REG(ZR)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (we),
    .dirEsc   (dirEsc),
    .datos    (datos),
    .dirLec1  (dirLec1),
    .dirLec2  (dirLec2),
    .clr      (clr),
    .datosOut1(datosOut1),
    .datosOut2(datosOut2),
    .listo    (listo)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a);
    if (ZR != 0 && a == 0) return '0;
    if (we && !clr && a == dirEsc) return datos;
    return m_mem[a];
  endfunction

  task automatic model_reset();
    m_ready = 1'b0;
    m_left  = DEPTH;
    m_o1    = '0;
    m_o2    = '0;
  endtask

  task automatic model_edge();
    if (!m_ready) begin
      m_o1 = '0;
      m_o2 = '0;
      m_left--;
      if (m_left == 0) begin
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        m_ready = 1'b1;
      end
    end else begin
      m_o1 = m_read(dirLec1);
      m_o2 = m_read(dirLec2);
      if (clr) begin
        m_ready = 1'b0;
        m_left  = DEPTH;
      end else if (we && !(ZR != 0 && dirEsc == 0)) begin
        m_mem[dirEsc] = datos;
      end
    end
  endtask

  // One clock edge: update the model from the current inputs, then compare.
  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    $display("t=%0t we=%0b clr=%0b esc=%0d d=%h l1=%0d l2=%0d -> o1=%h o2=%h listo=%0b",
             $time, we, clr, dirEsc, datos, dirLec1, dirLec2, datosOut1, datosOut2, listo);
    n_checks++;
    if (listo !== m_ready) begin
      n_fail++;
      $display("FAIL listo: got %0b expected %0b", listo, m_ready);
    end
    n_checks++;
    if (datosOut1 !== m_o1) begin
      n_fail++;
      $display("FAIL datosOut1: got %h expected %h", datosOut1, m_o1);
    end
    n_checks++;
    if (datosOut2 !== m_o2) begin
      n_fail++;
      $display("FAIL datosOut2: got %h expected %h", datosOut2, m_o2);
    end
  endtask

  task automatic idle_inputs();
    we = 0; clr = 0; dirEsc = '0; datos = '0; dirLec1 = '0; dirLec2 = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    #23;
    n_checks++;
    if (listo !== 1'b0 || datosOut1 !== '0 || datosOut2 !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got listo=%0b o1=%h o2=%h expected 0/0/0", listo, datosOut1, datosOut2);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_init();
    we = 1; dirEsc = 5'd3; datos = 32'hDEAD_BEEF;
    repeat (DEPTH) cycle();
    n_checks++;
    if (listo !== 1'b1) begin
      n_fail++;
      $display("FAIL init_listo_at_32: got %0b expected 1", listo);
    end
    idle_inputs();
    for (int a = 0; a < DEPTH; a++) begin
      dirLec1 = AW'(a);
      dirLec2 = AW'(DEPTH - 1 - a);
      cycle();
    end
    dirLec1 = 5'd3;
    cycle();
    n_checks++;
    if (datosOut1 !== '0) begin
      n_fail++;
      $display("FAIL init_ignored_write: got %h expected 0", datosOut1);
    end
  endtask

  task automatic test_write_read();
    we = 1; dirEsc = 5'd5; datos = 32'h1234_5678;
    cycle();
    dirEsc = 5'd6; datos = 32'hCAFE_0001;
    cycle();
    we = 0; dirLec1 = 5'd5; dirLec2 = 5'd6;
    cycle();
    n_checks++;
    if (datosOut1 !== 32'h1234_5678 || datosOut2 !== 32'hCAFE_0001) begin
      n_fail++;
      $display("FAIL write_read: got %h/%h expected 12345678/cafe0001", datosOut1, datosOut2);
    end
  endtask

  task automatic test_bypass();
    we = 1; dirEsc = 5'd7; datos = 32'hA5A5_A5A5; dirLec1 = 5'd7; dirLec2 = 5'd7;
    cycle();
    n_checks++;
    if (datosOut1 !== 32'hA5A5_A5A5 || datosOut2 !== 32'hA5A5_A5A5) begin
      n_fail++;
      $display("FAIL bypass: got %h/%h expected a5a5a5a5", datosOut1, datosOut2);
    end
    we = 0;
  endtask

  task automatic test_zero_reg();
    we = 1; dirEsc = 5'd0; datos = 32'hFFFF_FFFF; dirLec1 = 5'd0; dirLec2 = 5'd7;
    cycle();
    n_checks++;
    if (datosOut1 !== '0) begin
      n_fail++;
      $display("FAIL zero_reg_bypass: got %h expected 0", datosOut1);
    end
    we = 0;
    cycle();
    n_checks++;
    if (datosOut1 !== '0) begin
      n_fail++;
      $display("FAIL zero_reg_later: got %h expected 0", datosOut1);
    end
  endtask

  task automatic test_clr();
    int k;
    clr = 1; we = 1; dirEsc = 5'd9; datos = 32'h55; dirLec1 = 5'd5; dirLec2 = 5'd9;
    cycle();
    n_checks++;
    if (listo !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_drop_listo: got %0b expected 0", listo);
    end
    clr = 0; we = 0;
    k = 0;
    while (!listo && k < DEPTH + 8) begin
      cycle();
      k++;
    end
    n_checks++;
    if (k !== DEPTH) begin
      n_fail++;
      $display("FAIL clr_reinit_cycles: got %0d expected %0d", k, DEPTH);
    end
    dirLec1 = 5'd9; dirLec2 = 5'd5;
    cycle();
    n_checks++;
    if (datosOut1 !== '0 || datosOut2 !== '0) begin
      n_fail++;
      $display("FAIL clr_contents: got %h/%h expected 0/0", datosOut1, datosOut2);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      we      = 1'($urandom_range(0, 1));
      clr     = ($urandom_range(0, 63) == 0);
      dirEsc  = AW'($urandom_range(0, DEPTH - 1));
      datos   = DW'($urandom());
      dirLec1 = ($urandom_range(0, 3) == 0) ? dirEsc : AW'($urandom_range(0, DEPTH - 1));
      dirLec2 = ($urandom_range(0, 3) == 0) ? dirEsc : AW'($urandom_range(0, DEPTH - 1));
      cycle();
    end
    idle_inputs();
    for (int i = 0; i < DEPTH + 2 && !m_ready; i++) cycle();
  endtask

  task automatic test_async_reset();
    // Mid-operation: get non-zero outputs, then drop reset between edges.
    we = 1; dirEsc = 5'd12; datos = 32'h0BAD_F00D; dirLec1 = 5'd12; dirLec2 = 5'd12;
    cycle();
    we = 0;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (listo !== 1'b0 || datosOut1 !== '0 || datosOut2 !== '0) begin
      n_fail++;
      $display("FAIL async_rst_op: got listo=%0b o1=%h o2=%h expected 0/0/0", listo, datosOut1, datosOut2);
    end
    #10;
    rst_n = 1'b1;
    // Mid-INIT at cycle 10.
    repeat (10) cycle();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (listo !== 1'b0 || datosOut1 !== '0 || datosOut2 !== '0) begin
      n_fail++;
      $display("FAIL async_rst_init: got listo=%0b o1=%h o2=%h expected 0/0/0", listo, datosOut1, datosOut2);
    end
    #10;
    rst_n = 1'b1;
    repeat (DEPTH - 1) cycle();
    n_checks++;
    if (listo !== 1'b0) begin
      n_fail++;
      $display("FAIL async_rst_early_listo: got %0b expected 0", listo);
    end
    cycle();
    n_checks++;
    if (listo !== 1'b1) begin
      n_fail++;
      $display("FAIL async_rst_listo_32: got %0b expected 1", listo);
    end
    dirLec1 = 5'd12;
    cycle();
  endtask

  initial begin
    test_reset();
    test_init();
    test_write_read();
    test_bypass();
    test_zero_reg();
    test_clr();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
